// File: rtl/mem_load_unit_pkg.sv
// Shared types and constants for the load-side memory unit.
// Load-type codes follow the RISC-V funct3 field.
package mem_load_pkg;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    // Wide enough for any timeout up to 255.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic ld_ok(
        input logic [2:0] ctr,
        input logic [1:0] off
    );
        logic ok;
        ok = 1'b0;
        case (ctr)
            LD_LB, LD_LBU: ok = 1'b1;
            LD_LH, LD_LHU: ok = ~off[0];
            LD_LW:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// Request, memory-read and writeback signals of the load unit.
// The slave modport is the unit's view; master is its environment.
interface mem_load_unit_if;

    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_ctr;
    logic [31:0] ld_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        ld_err;

    modport slave (
        input  ld_valid,
        input  ld_ctr,
        input  ld_addr,
        input  mem_ack,
        input  mem_rdata,
        output ld_ready,
        output mem_req,
        output mem_addr,
        output rd_valid,
        output rd_data,
        output ld_err
    );

    modport master (
        output ld_valid,
        output ld_ctr,
        output ld_addr,
        output mem_ack,
        output mem_rdata,
        input  ld_ready,
        input  mem_req,
        input  mem_addr,
        input  rd_valid,
        input  rd_data,
        input  ld_err
    );

endinterface

// File: rtl/mem_load_unit_extend.sv
// Byte/halfword selection and sign/zero extension of a read word.
// Illegal load types produce zero.
module load_extend
    import mem_load_pkg::*;
(
    input  logic [2:0]  ld_ctr,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'h00;
        case (offset)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
    end

    assign half_v = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = 32'h0;
        case (ld_ctr)
            LD_LB:   result = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  result = {24'h0, byte_v};
            LD_LH:   result = {{16{half_v[15]}}, half_v};
            LD_LHU:  result = {16'h0, half_v};
            LD_LW:   result = word;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// Load unit: one outstanding word read, then align/extend to rd.
// Misaligned or illegal requests answer immediately with an error.
module mem_load_unit
    import mem_load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int XLEN           = 32
) (
    input logic             clk,
    input logic             rst_n,
    mem_load_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        ctr_q;
    logic [1:0]        off_q;
    logic              mem_req_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic              rd_valid_q;
    logic [XLEN-1:0]   rd_data_q;
    logic              ld_err_q;
    logic [XLEN-1:0]   ext_d;

    load_extend u_ext (
        .ld_ctr (ctr_q),
        .offset (off_q),
        .word   (bus.mem_rdata),
        .result (ext_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ctr_q      <= '0;
            off_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.ld_valid) begin
                        ctr_q <= bus.ld_ctr;
                        off_q <= bus.ld_addr[1:0];
                        cnt_q <= '0;
                        if (ld_ok(bus.ld_ctr, bus.ld_addr[1:0])) begin
                            state_q    <= WAIT;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {bus.ld_addr[31:2], 2'b00};
                        end else begin
                            state_q    <= RESP;
                            rd_valid_q <= 1'b1;
                            ld_err_q   <= 1'b1;
                            rd_data_q  <= '0;
                        end
                    end
                end
                WAIT: begin
                    // An ack in the last allowed cycle beats the timeout.
                    if (bus.mem_ack) begin
                        state_q    <= RESP;
                        mem_req_q  <= 1'b0;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= ext_d;
                        ld_err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= RESP;
                        mem_req_q  <= 1'b0;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= '0;
                        ld_err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ld_ready = (state_q == IDLE);
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.ld_err   = ld_err_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit with a small memory responder.
// Expected responses are queued at issue and checked by a monitor.
module tb_mem_load_unit;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t sbq[$];
    logic [31:0] memw [logic [29:0]];

    int   ack_delay = 0;
    logic force_ack = 1'b0;
    int   w = 0;
    int   last_len = 0;
    int   req_rises = 0;
    logic [31:0] first_addr = 32'h0;

    mem_load_unit_if bus();

    mem_load_unit #(
        .TIMEOUT_CYCLES(16),
        .XLEN(32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay cycles of mem_req.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!bus.mem_req) begin
                if (w > 0) last_len = w;
                w = 0;
                bus.mem_ack = force_ack;
            end else begin
                if (w == 0) begin
                    req_rises++;
                    first_addr = bus.mem_addr;
                end
                if (memw.exists(bus.mem_addr[31:2]))
                    bus.mem_rdata = memw[bus.mem_addr[31:2]];
                else
                    bus.mem_rdata = 32'h0;
                bus.mem_ack = (w == ack_delay);
                w++;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.rd_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = sbq.pop_front();
                chk("rd_data", bus.rd_data, x.d);
                chk("ld_err", {31'h0, bus.ld_err}, {31'h0, x.e});
                chk("rd_cycle", cyc, x.c);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.ld_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ld_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [2:0] ctr, input logic [31:0] addr,
                         input logic [31:0] d, input logic e,
                         input int lat, input bit push);
        exp_t x;
        wait_ready();
        bus.ld_ctr   = ctr;
        bus.ld_addr  = addr;
        bus.ld_valid = 1'b1;
        if (push) begin
            x.d = d;
            x.e = e;
            x.c = cyc + 1 + lat;
            sbq.push_back(x);
        end
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", sbq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int r0;
        exp_t x;
        int n;
        bus.ld_valid = 1'b0;
        bus.ld_ctr   = 3'b000;
        bus.ld_addr  = 32'h0;
        memw[30'h40] = 32'h80FF_1234;
        memw[30'h80] = 32'hBEEF_0011;
        memw[30'h04] = 32'h0000_8001;
        memw[30'h20] = 32'h1111_2222;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, bus.ld_ready}, 32'd1);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_rd_valid", {31'h0, bus.rd_valid}, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_ld_err", {31'h0, bus.ld_err}, 32'd0);
        rst_n = 1'b1;

        ack_delay = 0;
        issue(3'b000, 32'h103, 32'hFFFF_FF80, 1'b0, 1, 1'b1);
        drain();
        chk("lb_addr", first_addr, 32'h100);

        ack_delay = 3;
        issue(3'b101, 32'h202, 32'h0000_BEEF, 1'b0, 4, 1'b1);
        drain();
        chk("lhu_addr", first_addr, 32'h200);
        chk("lhu_req_len", last_len, 4);

        r0 = req_rises;
        issue(3'b010, 32'h005, 32'h0, 1'b1, 0, 1'b1);
        issue(3'b011, 32'h008, 32'h0, 1'b1, 0, 1'b1);
        issue(3'b001, 32'h021, 32'h0, 1'b1, 0, 1'b1);
        drain();
        chk("err_no_req", req_rises, r0);

        ack_delay = 1000;
        issue(3'b010, 32'h040, 32'h0, 1'b1, 16, 1'b1);
        drain();
        chk("to_req_len", last_len, 16);
        chk("to_addr", first_addr, 32'h40);
        force_ack = 1'b1;
        repeat (3) @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("to_ready", {31'h0, bus.ld_ready}, 32'd1);

        ack_delay = 0;
        r0 = req_rises;
        wait_ready();
        bus.ld_ctr   = 3'b001;
        bus.ld_addr  = 32'h10;
        bus.ld_valid = 1'b1;
        x.d = 32'hFFFF_8001;
        x.e = 1'b0;
        x.c = cyc + 2;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        bus.ld_ctr  = 3'b100;
        bus.ld_addr = 32'h13;
        n = 0;
        @(negedge clk);
        while (!bus.ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        memw[30'h04] = 32'hAB00_0000;
        x.d = 32'h0000_00AB;
        x.e = 1'b0;
        x.c = cyc + 2;
        sbq.push_back(x);
        @(posedge clk);
        #1 bus.ld_valid = 1'b0;
        drain();
        chk("b2b_req_count", req_rises, r0 + 2);

        ack_delay = 20;
        issue(3'b010, 32'h080, 32'h0, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_mem_req", {31'h0, bus.mem_req}, 32'd0);
        chk("midrst_ready", {31'h0, bus.ld_ready}, 32'd1);
        repeat (5) @(negedge clk);

        ack_delay = 1;
        issue(3'b100, 32'h101, 32'h0000_0012, 1'b0, 2, 1'b1);
        issue(3'b001, 32'h102, 32'hFFFF_80FF, 1'b0, 2, 1'b1);
        issue(3'b000, 32'h100, 32'h0000_0034, 1'b0, 2, 1'b1);
        issue(3'b010, 32'h080, 32'h1111_2222, 1'b0, 2, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
